// File: rtl/rf_wb_arbiter_if.sv
// Writeback record type and the bus bundle between rf_wb_arbiter and its
// neighbours (pipeline writeback, multi-cycle unit, decode, rf write port).
package rf_wb_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;
  } writeback_signals;
endpackage

interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  writeback_signals pipe_in;
  logic             pipe_stall;
  logic             mc_valid;
  logic             mc_ready;
  logic [4:0]       mc_rd_addr;
  logic [XLEN-1:0]  mc_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_busy;
  logic             rs2_busy;
  writeback_signals wb_out;

  modport master (
    output pipe_in, mc_valid, mc_rd_addr, mc_data,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  pipe_stall, mc_ready, rs1_busy, rs2_busy, wb_out
  );

  modport slave (
    input  pipe_in, mc_valid, mc_rd_addr, mc_data,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    output pipe_stall, mc_ready, rs1_busy, rs2_busy, wb_out
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (pipeline vs multi-cycle unit) with a pending-write
// scoreboard. Define RF_WB_STARVE_GUARD_EN to build the multi-cycle starvation guard.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arbiter_if.slave bus
);
  import rf_wb_pkg::*;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [31:1]      busy;
  logic [31:0]      busy_view;
  logic [31:1]      set_mask;
  logic [31:1]      clr_mask;
  logic             handshake;
  writeback_signals mc_wb;

  assign mc_wb.rd_addr = bus.mc_rd_addr;
  assign mc_wb.data    = bus.mc_data;

  // Grant: a forced stall hands the port to the multi-cycle unit, otherwise a real
  // pipeline write wins, otherwise the multi-cycle unit may use the idle port.
  always_comb begin
    bus.mc_ready = 1'b1;
    bus.wb_out   = '0;
    if (bus.pipe_stall) begin
      bus.wb_out = mc_wb;
    end else if (bus.pipe_in.rd_addr != '0) begin
      bus.mc_ready = 1'b0;
      bus.wb_out   = bus.pipe_in;
    end else if (bus.mc_valid) begin
      bus.wb_out = mc_wb;
    end
  end

  assign handshake = bus.mc_valid && bus.mc_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      set_mask[i] = bus.issue_valid && (bus.issue_rd == 5'(i));
      clr_mask[i] = handshake && (bus.mc_rd_addr == 5'(i));
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign busy_view    = {busy, 1'b0};
  assign bus.rs1_busy = busy_view[bus.rs1_addr];
  assign bus.rs2_busy = busy_view[bus.rs2_addr];

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.mc_valid || handshake) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign bus.pipe_stall = bus.mc_valid && (starve_cnt == LIMIT);
`else
  assign bus.pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised + directed bench for rf_wb_arbiter; a behavioural model queues the
// expected outputs per cycle and a monitor compares them at the falling edge.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit              rst;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    bit              mc_valid;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    bit              issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } stim_t;

  typedef struct {
    string           tag;
    bit              stall;
    bit              ready;
    bit              rs1b;
    bit              rs2b;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          model_busy[32];
  int unsigned blocked     = 0;
  bit          mc_held     = 1'b0;
  bit          guard_on;
  stim_t       last;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.pipe_rd = '0; s.pipe_data = '0; s.mc_valid = 1'b0;
    s.mc_rd = '0; s.mc_data = '0; s.issue_valid = 1'b0; s.issue_rd = '0;
    s.rs1 = '0; s.rs2 = '0;
    return s;
  endfunction

  // Reference: ownership rules, a per-register pending flag array and a count of
  // consecutive cycles the multi-cycle result has been left waiting.
  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                  = s.rst ? 1'b0 : 1'b1;
    bus.pipe_in.rd_addr    = s.pipe_rd;
    bus.pipe_in.data       = s.pipe_data;
    bus.mc_valid           = s.mc_valid;
    bus.mc_rd_addr         = s.mc_rd;
    bus.mc_data            = s.mc_data;
    bus.issue_valid        = s.issue_valid;
    bus.issue_rd           = s.issue_rd;
    bus.rs1_addr           = s.rs1;
    bus.rs2_addr           = s.rs2;
    if (s.rst) begin
      for (int i = 0; i < 32; i++) model_busy[i] = 1'b0;
      blocked = 0;
    end
    e.tag     = tag;
    e.stall   = guard_on && s.mc_valid && (blocked == LIMIT);
    e.ready   = 1'b1;
    e.wb_rd   = '0;
    e.wb_data = '0;
    if (e.stall) begin
      e.wb_rd = s.mc_rd; e.wb_data = s.mc_data;
    end else if (s.pipe_rd != 0) begin
      e.ready = 1'b0; e.wb_rd = s.pipe_rd; e.wb_data = s.pipe_data;
    end else if (s.mc_valid) begin
      e.wb_rd = s.mc_rd; e.wb_data = s.mc_data;
    end
    e.rs1b = model_busy[s.rs1];
    e.rs2b = model_busy[s.rs2];
    exp_q.push_back(e);
    if (!s.rst) begin
      if (s.mc_valid && e.ready && s.mc_rd != 0) model_busy[s.mc_rd] = 1'b0;
      if (s.issue_valid && s.issue_rd != 0)      model_busy[s.issue_rd] = 1'b1;
      blocked = (s.mc_valid && !e.ready) ? blocked + 1 : 0;
      mc_held = s.mc_valid && !e.ready;
    end else begin
      mc_held = 1'b0;
    end
    last = s;
  endtask

  task automatic chk(input string tag, input string name,
                     input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s.%s: got %h, expected %h", tag, name, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "pipe_stall", XLEN'(bus.pipe_stall), XLEN'(e.stall));
        chk(e.tag, "mc_ready",   XLEN'(bus.mc_ready),   XLEN'(e.ready));
        chk(e.tag, "wb_rd",      XLEN'(bus.wb_out.rd_addr), XLEN'(e.wb_rd));
        chk(e.tag, "wb_data",    bus.wb_out.data,       e.wb_data);
        chk(e.tag, "rs1_busy",   XLEN'(bus.rs1_busy),   XLEN'(e.rs1b));
        chk(e.tag, "rs2_busy",   XLEN'(bus.rs2_busy),   XLEN'(e.rs2b));
      end
    end
  end

  initial begin : driver
    stim_t s;
`ifdef RF_WB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    rst_n = 1'b0;
    s = idle(); s.rst = 1'b1;
    apply(s, "reset");
    apply(s, "reset2");

    // issue to r5: invisible this cycle, visible the next; r0 never busy
    s = idle(); s.issue_valid = 1'b1; s.issue_rd = 5'd5; s.rs1 = 5'd5;
    apply(s, "issue5_same");
    s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd0;
    apply(s, "issue5_next");

    // pipeline beats pending r7 result, r7 then drains and clears
    s = idle(); s.issue_valid = 1'b1; s.issue_rd = 5'd7;
    apply(s, "issue7");
    s = idle(); s.pipe_rd = 5'd3; s.pipe_data = 32'hAA;
    s.mc_valid = 1'b1; s.mc_rd = 5'd7; s.mc_data = 32'h1234_5678; s.rs1 = 5'd7;
    apply(s, "pipe_wins");
    s.pipe_rd = 5'd0; s.pipe_data = 32'h0;
    apply(s, "mc_drains");
    s = idle(); s.rs1 = 5'd7; s.rs2 = 5'd5;
    apply(s, "r7_cleared");

    s = idle(); s.mc_valid = 1'b1; s.mc_rd = 5'd0; s.mc_data = 32'hDEAD_BEEF;
    apply(s, "mc_rd0");

    // same-cycle reissue beats clear
    s = idle(); s.issue_valid = 1'b1; s.issue_rd = 5'd9;
    apply(s, "issue9");
    s = idle(); s.issue_valid = 1'b1; s.issue_rd = 5'd9;
    s.mc_valid = 1'b1; s.mc_rd = 5'd9; s.mc_data = 32'h0909_0909; s.rs1 = 5'd9;
    apply(s, "set_wins");
    s = idle(); s.rs1 = 5'd9;
    apply(s, "r9_still");

    // block for 3 cycles with r12 pending, then reset mid-operation
    s = idle(); s.issue_valid = 1'b1; s.issue_rd = 5'd12;
    apply(s, "issue12");
    s = idle(); s.pipe_rd = 5'd2; s.pipe_data = 32'h2222;
    s.mc_valid = 1'b1; s.mc_rd = 5'd4; s.mc_data = 32'h4444; s.rs1 = 5'd12;
    for (int i = 0; i < 3; i++) apply(s, "block_pre");
    s.rst = 1'b1;
    apply(s, "mid_reset");
    s.rst = 1'b0;
    for (int i = 0; i < 7; i++) apply(s, "starve");

    for (int n = 0; n < 500; n++) begin
      s = idle();
      s.pipe_rd   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.pipe_data = $urandom;
      if (mc_held) begin
        s.mc_valid = 1'b1; s.mc_rd = last.mc_rd; s.mc_data = last.mc_data;
      end else begin
        s.mc_valid = ($urandom_range(0, 2) != 0);
        s.mc_rd    = 5'($urandom_range(0, 15));
        s.mc_data  = $urandom;
      end
      s.issue_valid = ($urandom_range(0, 1) == 1);
      s.issue_rd    = 5'($urandom_range(0, 15));
      s.rs1         = 5'($urandom_range(0, 15));
      s.rs2         = 5'($urandom_range(0, 15));
      s.rst         = ($urandom_range(0, 99) == 0);
      apply(s, "random");
    end

    s = idle();
    apply(s, "tail");
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
